// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default geometry,
// clear-sequencer state encoding and the hardwired zero register index.
package regfile_pkg;

   // Default geometry: 32 registers of 32 bits.
   localparam int DEF_DW = 32;
   localparam int DEF_AW = 5;

   // Register index that is hardwired to zero.
   localparam int ZERO_REG = 0;

   // Clear sequencer states.
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } clr_state_e;

   // True when a register index names a real, writable register.
   function automatic logic is_live_reg(input int unsigned idx);
      return idx != ZERO_REG;
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer. After reset deasserts it walks registers
// 1..DEPTH-1, writing zero into each one per clock, then raises o_ready.
// Register 0 is skipped because it is never read from the array.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int AW    = DEF_AW,
   parameter int DEPTH = 1 << AW
)
(
   input  logic          i_clk,
   input  logic          i_reset,
   output logic          o_clr_we,
   output logic [AW-1:0] o_clr_addr,
   output logic          o_ready,
   output clr_state_e    o_dbg_state
);

   localparam logic [AW-1:0] FIRST_ADDR = AW'(1);
   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);

   clr_state_e    r_state;
   clr_state_e    w_state_nxt;
   logic [AW-1:0] r_cnt;

   // State and counter registers; reset restarts the walk at register 1.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_CLEAR;
         r_cnt   <= FIRST_ADDR;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + AW'(1);
         end
      end
   end

   // Next state: leave CLEAR once the last register has been written.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: begin
            if (r_cnt == LAST_ADDR) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_CLEAR;
         end
      endcase
   end

   // Outputs: a clear write is issued on every non-reset edge in CLEAR.
   always_comb begin
      o_clr_we    = 1'b0;
      o_clr_addr  = r_cnt;
      o_ready     = 1'b0;
      o_dbg_state = r_state;
      case (r_state)
         ST_CLEAR: o_clr_we = ~i_reset;
         ST_RUN:   o_ready  = 1'b1;
         default:  o_clr_we = 1'b0;
      endcase
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass, two write ports
// (0 = ALU writeback, 1 = load writeback, load wins on a collision), a
// per-register busy scoreboard for issue hazards and a post-reset clear.
//
// Handshake: there is no valid/ready flow control on the data paths; every
// input is taken as a request in the cycle it is presented. The single
// ready output only tells the pipeline the file is usable: while it is
// low, writes and issues are dropped and all read-side outputs are 0.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int AW    = DEF_AW,
   parameter int DEPTH = 1 << AW,
   parameter int NREAD = 2
)
(
   input  logic                clk,
   input  logic                reset,
   output logic                ready,
   input  logic [NREAD*AW-1:0] ra,
   output logic [NREAD*DW-1:0] rd,
   output logic [NREAD-1:0]    rbusy,
   input  logic                we0,
   input  logic                we1,
   input  logic [AW-1:0]       wa0,
   input  logic [AW-1:0]       wa1,
   input  logic [DW-1:0]       wd0,
   input  logic [DW-1:0]       wd1,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_addr,
   output logic                issue_stall
);

   localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

   logic [DW-1:0]    r_mem [DEPTH];
   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;

   logic             w_clr_we;
   logic [AW-1:0]    w_clr_addr;
   logic             w_ready;
   clr_state_e       w_seq_state;

   logic             w_run;
   logic             w_we0;
   logic             w_we1;
   logic             w_iss;
   logic             w_iss_hit0;
   logic             w_iss_hit1;

   regfile_clear_seq #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_clear_seq (
      .i_clk       (clk),
      .i_reset     (reset),
      .o_clr_we    (w_clr_we),
      .o_clr_addr  (w_clr_addr),
      .o_ready     (w_ready),
      .o_dbg_state (w_seq_state)
   );

   assign ready = w_ready;

   // Normal operation only outside CLEAR; a pending synchronous reset also
   // blocks it so nothing leaks through in the reset cycle.
   assign w_run = (w_seq_state == ST_RUN) & ~reset;

   // Qualified write/issue requests; register 0 is never a target.
   assign w_we0 = w_run & we0 & (wa0 != ZERO_ADDR);
   assign w_we1 = w_run & we1 & (wa1 != ZERO_ADDR);
   assign w_iss = w_run & issue_en & (issue_addr != ZERO_ADDR);

   // Storage: the clear walk and pipeline writes never overlap in time.
   // Port 1 is assigned last so the load wins on an address collision.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[w_clr_addr] <= '0;
      end else begin
         if (w_we0) begin
            r_mem[wa0] <= wd0;
         end
         if (w_we1) begin
            r_mem[wa1] <= wd1;
         end
      end
   end

   // Scoreboard update: writebacks clear, issue sets; set applied last wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_we0) begin
         w_busy_nxt[wa0] = 1'b0;
      end
      if (w_we1) begin
         w_busy_nxt[wa1] = 1'b0;
      end
      if (w_iss) begin
         w_busy_nxt[issue_addr] = 1'b1;
      end
   end

   // Busy vector register, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // Read ports with same-cycle bypass from both write ports.
   for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [AW-1:0] w_a;
      logic          w_hit0;
      logic          w_hit1;

      assign w_a    = ra[g*AW +: AW];
      assign w_hit0 = w_we0 & (wa0 == w_a);
      assign w_hit1 = w_we1 & (wa1 == w_a);

      assign rd[g*DW +: DW] = (!w_run || w_a == ZERO_ADDR) ? '0    :
                              w_hit1                       ? wd1   :
                              w_hit0                       ? wd0   :
                                                             r_mem[w_a];

      // A register being written this cycle is no longer pending.
      assign rbusy[g] = w_run & r_busy[w_a] & ~w_hit0 & ~w_hit1;
   end

   // WAW hazard flag: advisory only, the issue still marks the register.
   assign w_iss_hit0  = w_we0 & (wa0 == issue_addr);
   assign w_iss_hit1  = w_we1 & (wa1 == issue_addr);
   assign issue_stall = w_run & issue_en & r_busy[issue_addr] &
                        ~w_iss_hit0 & ~w_iss_hit1;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb. A driver applies one
// request per cycle and pushes the expected outputs, derived from a
// behavioural model, into a queue; a monitor on the falling edge pops and
// compares each entry against the DUT outputs.
module tb_regfile_sb;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 1 << AW;
   localparam int NREAD = 2;
   localparam int EW    = 2 + NREAD + NREAD * DW;

   // ---------------- clock / reset / DUT ----------------
   logic                clk;
   logic                reset;
   logic                ready;
   logic [NREAD*AW-1:0] ra;
   logic [NREAD*DW-1:0] rd;
   logic [NREAD-1:0]    rbusy;
   logic                we0, we1;
   logic [AW-1:0]       wa0, wa1;
   logic [DW-1:0]       wd0, wd1;
   logic                issue_en;
   logic [AW-1:0]       issue_addr;
   logic                issue_stall;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   regfile_sb #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NREAD(NREAD)) dut (
      .clk         (clk),
      .reset       (reset),
      .ready       (ready),
      .ra          (ra),
      .rd          (rd),
      .rbusy       (rbusy),
      .we0         (we0),
      .we1         (we1),
      .wa0         (wa0),
      .wa1         (wa1),
      .wd0         (wd0),
      .wd1         (wd1),
      .issue_en    (issue_en),
      .issue_addr  (issue_addr),
      .issue_stall (issue_stall)
   );

   // ---------------- reference model ----------------
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_busy [DEPTH];
   int            m_edges;   // non-reset edges since the last reset

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   string         tag_q[$];
   int            n_cmp;
   int            n_err;

   // ---------------- driver ----------------
   task automatic drive(input string tag, input bit rst,
                        input bit e0, input int a0, input logic [DW-1:0] d0,
                        input bit e1, input int a1, input logic [DW-1:0] d1,
                        input bit ie, input int ia, input int r0, input int r1);
      bit                  m_ready;
      bit                  run;
      logic [NREAD*DW-1:0] erd;
      logic [NREAD-1:0]    eb;
      bit                  est;
      int                  ras [NREAD];

      reset      = rst;
      we0        = e0;
      wa0        = AW'(a0);
      wd0        = d0;
      we1        = e1;
      wa1        = AW'(a1);
      wd1        = d1;
      issue_en   = ie;
      issue_addr = AW'(ia);
      ra         = {AW'(r1), AW'(r0)};

      // Expected outputs from the pre-edge model state.
      m_ready = (m_edges >= DEPTH - 1);
      run     = m_ready && !rst;
      ras[0]  = r0;
      ras[1]  = r1;
      erd     = '0;
      eb      = '0;
      for (int i = 0; i < NREAD; i++) begin
         int a;
         bit h0, h1;
         a  = ras[i];
         h0 = e0 && (a0 == a);
         h1 = e1 && (a1 == a);
         if (run && a != 0) begin
            erd[i*DW +: DW] = h1 ? d1 : (h0 ? d0 : m_mem[a]);
            eb[i]           = m_busy[a] && !h0 && !h1;
         end
      end
      est = run && ie && m_busy[ia] &&
            !(e0 && a0 == ia && ia != 0) && !(e1 && a1 == ia && ia != 0);
      exp_q.push_back({m_ready, est, eb, erd});
      tag_q.push_back(tag);

      @(posedge clk);

      // Advance the model across the edge.
      if (rst) begin
         m_edges = 0;
         for (int r = 0; r < DEPTH; r++) m_busy[r] = 0;
      end else if (!m_ready) begin
         m_edges++;
         if (m_edges == DEPTH - 1) begin
            for (int r = 0; r < DEPTH; r++) m_mem[r] = '0;
         end
      end else begin
         if (e0 && a0 != 0) m_mem[a0] = d0;
         if (e1 && a1 != 0) m_mem[a1] = d1;
         if (e0 && a0 != 0) m_busy[a0] = 0;
         if (e1 && a1 != 0) m_busy[a1] = 0;
         if (ie && ia != 0) m_busy[ia] = 1;
      end
      #1;
   endtask

   task automatic idle(input string tag, input int r0, input int r1);
      drive(tag, 0, 0, 0, '0, 0, 0, '0, 0, 0, r0, r1);
   endtask

   task automatic do_reset(input string tag);
      drive(tag, 1, 0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [EW-1:0] e;
         logic [EW-1:0] got;
         string         t;
         e   = exp_q.pop_front();
         t   = tag_q.pop_front();
         got = {ready, issue_stall, rbusy, rd};
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL %s: got ready=%b stall=%b rbusy=%b rd=%h, want ready=%b stall=%b rbusy=%b rd=%h",
                     t, got[EW-1], got[EW-2], got[EW-3 -: NREAD], got[NREAD*DW-1:0],
                     e[EW-1], e[EW-2], e[EW-3 -: NREAD], e[NREAD*DW-1:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      n_cmp      = 0;
      n_err      = 0;
      m_edges    = 0;
      for (int r = 0; r < DEPTH; r++) begin
         m_mem[r]  = '0;
         m_busy[r] = 0;
      end
      reset      = 1'b1;
      we0        = 1'b0;
      we1        = 1'b0;
      wa0        = '0;
      wa1        = '0;
      wd0        = '0;
      wd1        = '0;
      issue_en   = 1'b0;
      issue_addr = '0;
      ra         = '0;
      @(posedge clk);
      #1;

      // 1: reset, clear walk timing, all registers zero afterwards
      do_reset("t1_reset");
      do_reset("t1_reset");
      for (int k = 0; k < 33; k++) idle("t1_ready", k % DEPTH, (DEPTH - 1 - k) % DEPTH);
      for (int r = 0; r < DEPTH; r += 2) idle("t1_zero", r, r + 1);

      // 2: ALU write with same-cycle bypass, then array read
      drive("t2_bypass", 0, 1, 5, 32'hDEAD_BEEF, 0, 0, '0, 0, 0, 5, 0);
      idle("t2_array", 5, 0);

      // 3: load port wins a collision; register 0 ignores writes
      drive("t3_prio", 0, 1, 7, 32'd1, 1, 7, 32'd2, 0, 0, 7, 7);
      idle("t3_reg7", 7, 0);
      drive("t3_r0_wr", 0, 1, 0, 32'hFFFF_FFFF, 0, 0, '0, 0, 0, 0, 7);
      idle("t3_r0_rd", 0, 0);

      // 4: scoreboard set, WAW stall, clear by load writeback
      drive("t4_issue", 0, 0, 0, '0, 0, 0, '0, 1, 9, 9, 9);
      idle("t4_busy", 9, 0);
      drive("t4_waw", 0, 0, 0, '0, 0, 0, '0, 1, 9, 9, 0);
      drive("t4_wb", 0, 0, 0, '0, 1, 9, 32'hCAFE_0009, 0, 0, 9, 9);
      idle("t4_after", 9, 0);

      // 5: set wins over clear; write in same cycle suppresses the stall
      drive("t5_pre", 0, 0, 0, '0, 0, 0, '0, 1, 4, 4, 0);
      drive("t5_same", 0, 1, 4, 32'h0000_1234, 0, 0, '0, 1, 4, 4, 4);
      idle("t5_after", 4, 0);
      drive("t5_r0_iss", 0, 0, 0, '0, 0, 0, '0, 1, 0, 0, 4);

      // 6: garbage, reset mid-clear, ignored traffic during CLEAR
      drive("t6_junk", 0, 1, 12, 32'h5A5A_A5A5, 1, 13, 32'h1111_2222, 1, 14, 12, 13);
      do_reset("t6_reset");
      for (int k = 0; k < 10; k++) idle("t6_clr", 12, 13);
      do_reset("t6_reset2");
      drive("t6_ign", 0, 1, 3, 32'hBAD0_0003, 1, 6, 32'hBAD0_0006, 1, 3, 3, 6);
      drive("t6_ign", 0, 0, 0, '0, 0, 0, '0, 1, 6, 3, 6);
      for (int k = 0; k < 31; k++) idle("t6_ready", 3, 14);
      for (int r = 0; r < DEPTH; r += 2) idle("t6_zero", r, r + 1);
      drive("t6_iss_clr", 0, 0, 0, '0, 0, 0, '0, 1, 3, 3, 6);

      // Randomised traffic concentrated on a few registers
      for (int n = 0; n < 600; n++) begin
         bit            rst;
         bit            e0, e1, ie;
         int            a0, a1, ia, r0, r1, hi;
         logic [DW-1:0] d0, d1;
         hi  = ($urandom_range(0, 3) == 0) ? DEPTH - 1 : 7;
         rst = ($urandom_range(0, 249) == 0);
         e0  = $urandom_range(0, 1);
         e1  = $urandom_range(0, 2) == 0;
         ie  = $urandom_range(0, 1);
         a0  = $urandom_range(0, hi);
         a1  = $urandom_range(0, hi);
         ia  = $urandom_range(0, hi);
         r0  = $urandom_range(0, hi);
         r1  = $urandom_range(0, hi);
         d0  = $urandom;
         d1  = $urandom;
         drive("rand", rst, e0, a0, d0, e1, a1, d1, ie, ia, r0, r1);
      end

      // Drain: the monitor must have consumed every expectation.
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the single-write, two-read MIPS register file.
- Adds NREAD read ports with write-to-read bypass and two write ports: port 0 for ALU writeback, port 1 for load writeback.
- Adds a per-register busy scoreboard for issue hazards, register 0 hardwired to zero, and a post-reset clear sequencer.
- Sits between the decode/issue stage and the writeback stage of the pipeline.

Parameters:
- DW, 32, data width in bits.
- AW, 5, register address width.
- DEPTH, 1<<AW, number of registers (minimum 2).
- NREAD, 2, number of read ports (minimum 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ready  output  1  high once the clear sequence has finished.
- ra  input  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd  output  NREAD*DW  read data; port i occupies bits [i*DW +: DW].
- rbusy  output  NREAD  busy bit of each read port's register, after bypass.
- we0, we1  input  1 each  write enables (port 0 = ALU, port 1 = load).
- wa0, wa1  input  AW each  write addresses.
- wd0, wd1  input  DW each  write data.
- issue_en  input  1  marks issue_addr as having a pending write.
- issue_addr  input  AW  destination register being issued.
- issue_stall  output  1  WAW hazard: issue targets a register that is still busy.

Behaviour:
- Storage: DEPTH x DW array plus a DEPTH-bit busy vector. The array is not reset directly; it is cleared by the sequencer.
- Register 0:
  - always reads 0;
  - writes to it are ignored;
  - its busy bit is never set;
  - issue to register 0 never stalls.
- Writes: synchronous, on the rising edge, when weN=1 and waN!=0.
  - If wa0==wa1 with both enabled, port 1 (load) wins.
- Reads: combinational, with bypass.
  - If ra_i matches an enabled write port this cycle (address !=0), rd_i returns that write's data, using the same port-1 priority.
  - Otherwise rd_i returns the array content.
- rbusy_i = busy[ra_i] AND NOT (an enabled write targets ra_i this cycle).
- Scoreboard, evaluated on the rising edge:
  - An enabled write to register r clears busy[r].
  - issue_en with issue_addr=r (r!=0) sets busy[r].
  - If a set and a clear hit the same register in the same cycle, the set wins.
- issue_stall = issue_en AND busy[issue_addr] AND NOT (write to issue_addr this cycle). It is combinational and advisory; the scoreboard still sets the bit.
- Clear FSM, two states, CLEAR and RUN:
  - reset=1 forces CLEAR, cnt=1, all busy bits to 0 and ready=0.
  - In CLEAR, on each rising edge with reset=0, the sequencer writes array[cnt]=0 and increments cnt.
  - After writing cnt=DEPTH-1 it moves to RUN and ready becomes 1.
  - ready therefore rises at the (DEPTH-1)th rising edge after reset deasserts: 31 edges at the default DEPTH.
  - While in CLEAR: we0, we1 and issue_en are ignored, rd is forced to 0, rbusy is 0 and issue_stall is 0.
  - Reset asserted mid-CLEAR or in RUN restarts the sequence from cnt=1.
- Reset values: ready=0, busy=0, rd=0, rbusy=0, issue_stall=0.
- No pipeline latency: read and bypass are same-cycle; write data is visible in the array from the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - default DW and AW;
  - the state encoding (CLEAR=1'b0, RUN=1'b1);
  - the zero-register constant (0).
- Sub-module regfile_clear_seq holds the FSM and the AW-bit counter.
  - Outputs: clr_we, clr_addr, ready.
  - The top muxes clr_we/clr_addr onto the array's write path during CLEAR.

Test Plan:
1. Reset for 2 cycles, then release with default parameters → ready=0 for 30 edges and 1 at edge 31; every register reads 0; pre-loaded garbage is gone.
2. Write we0 wa0=5 wd0=32'hDEAD_BEEF while ra[0]=5 in the same cycle → rd[0]=DEADBEEF combinationally (bypass); the next cycle still reads DEADBEEF from the array.
3. Same cycle: we0 wa0=7 wd0=1 and we1 wa1=7 wd1=2 → reg 7 reads 2. Write 32'hFFFF_FFFF to reg 0 → reg 0 reads 0.
4. issue_en to reg 9 → busy[9]=1 and rbusy=1 for ra=9. A second issue to reg 9 → issue_stall=1. we1 wa1=9 → rbusy=0 in that cycle, busy cleared on the next edge.
5. Same cycle: issue_en reg 4 and we0 wa0=4 → issue_stall=0; after the edge busy[4]=1 (set wins) and the array holds wd0.
6. Assert reset for 1 cycle at clear step 10, then release → sequence restarts; ready at the 31st edge after release. we0 and issue_en applied during CLEAR leave no effect.
